// File: rtl/fpa_scheduler.sv
// Two-requester arbiter and sequencer for a shared pipelined floating_point_adder.
// Optional build macro: FPA_SCHED_FIXED_PRIO_EN (fixed priority to r0 instead of round-robin).
module fpa_scheduler #(
  parameter int PIPE_DEPTH = 4,
  parameter int OP_STAGE   = 2
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r0_op,
  output logic        r0_res_valid,
  output logic [31:0] r0_res,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic        r1_op,
  output logic        r1_res_valid,
  output logic [31:0] r1_res,
  output logic [15:0] fpa_exponenti,
  output logic [47:0] fpa_mantise,
  output logic        fpa_load,
  output logic        fpa_clear,
  output logic        fpa_op,
  input  logic [7:0]  fpa_rez_exp,
  input  logic [23:0] fpa_rez_mant,
  output logic        busy,
  output logic [3:0]  inflight
);

  // Handshake: a request transfers on the rising edge where rN_valid & rN_ready are both high;
  // ready is combinational from valid and never asserted while clear is high. Results have no backpressure.
  logic grant0, grant1;

  logic        st_valid_q, st_valid_d;
  logic        st_owner_q, st_owner_d;
  logic        st_op_q, st_op_d;
  logic [15:0] exp_q, exp_d;
  logic [47:0] mant_q, mant_d;

  logic [PIPE_DEPTH-1:0] tv_q, tv_d;
  logic [PIPE_DEPTH-1:0] to_q, to_d;
  logic [PIPE_DEPTH-1:0] top_q, top_d;

  logic        ret_valid_q, ret_valid_d;
  logic        ret_owner_q, ret_owner_d;
  logic        r0_res_valid_q, r0_res_valid_d;
  logic        r1_res_valid_q, r1_res_valid_d;
  logic [31:0] r0_res_q, r0_res_d;
  logic [31:0] r1_res_q, r1_res_d;
  logic        fpa_clear_q, fpa_clear_d;

  logic [31:0] sel_a, sel_b;
  logic [31:0] rez_word;
  logic [3:0]  cnt;

`ifdef FPA_SCHED_FIXED_PRIO_EN
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!clear) begin
      if (r0_valid) grant0 = 1'b1;
      else if (r1_valid) grant1 = 1'b1;
    end
  end
`else
  // rr_last_q holds the most recently granted requester; reset value 1 lets r0 win the first tie.
  logic rr_last_q, rr_last_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!clear) begin
      if (r0_valid && r1_valid) begin
        if (rr_last_q) grant0 = 1'b1;
        else grant1 = 1'b1;
      end else begin
        grant0 = r0_valid;
        grant1 = r1_valid;
      end
    end
    rr_last_d = rr_last_q;
    if (grant0) rr_last_d = 1'b0;
    else if (grant1) rr_last_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear) rr_last_q <= 1'b1;
    else rr_last_q <= rr_last_d;
  end
`endif

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // The adder is advanced whenever anything is staged or tracked, so latency is fixed.
  assign fpa_load = st_valid_q | (|tv_q);
  assign rez_word = {fpa_rez_mant[23], fpa_rez_exp, fpa_rez_mant[22:0]};

  always_comb begin
    sel_a = grant1 ? r1_a : r0_a;
    sel_b = grant1 ? r1_b : r0_b;

    st_valid_d = grant0 | grant1;
    st_owner_d = grant1;
    st_op_d    = grant1 ? r1_op : (grant0 ? r0_op : 1'b0);
    exp_d      = 16'd0;
    mant_d     = 48'd0;
    if (grant0 || grant1) begin
      exp_d  = {sel_a[30:23], sel_b[30:23]};
      mant_d = {sel_a[31], sel_a[22:0], sel_b[31], sel_b[22:0]};
    end

    tv_d  = tv_q;
    to_d  = to_q;
    top_d = top_q;
    if (fpa_load) begin
      tv_d[0]  = st_valid_q;
      to_d[0]  = st_owner_q;
      top_d[0] = st_op_q;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        tv_d[i]  = tv_q[i-1];
        to_d[i]  = to_q[i-1];
        top_d[i] = top_q[i-1];
      end
    end

    // An entry leaving the last position has its result on rez_* one edge later.
    ret_valid_d = fpa_load & tv_q[PIPE_DEPTH-1];
    ret_owner_d = to_q[PIPE_DEPTH-1];

    r0_res_valid_d = ret_valid_q & ~ret_owner_q;
    r1_res_valid_d = ret_valid_q & ret_owner_q;
    r0_res_d       = r0_res_valid_d ? rez_word : r0_res_q;
    r1_res_d       = r1_res_valid_d ? rez_word : r1_res_q;

    fpa_clear_d = clear;

    cnt = {3'b000, st_valid_q};
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      cnt = cnt + {3'b000, tv_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    fpa_clear_q <= fpa_clear_d;
    if (clear) begin
      st_valid_q     <= 1'b0;
      st_owner_q     <= 1'b0;
      st_op_q        <= 1'b0;
      exp_q          <= 16'd0;
      mant_q         <= 48'd0;
      tv_q           <= '0;
      to_q           <= '0;
      top_q          <= '0;
      ret_valid_q    <= 1'b0;
      ret_owner_q    <= 1'b0;
      r0_res_valid_q <= 1'b0;
      r1_res_valid_q <= 1'b0;
      r0_res_q       <= 32'd0;
      r1_res_q       <= 32'd0;
    end else begin
      st_valid_q     <= st_valid_d;
      st_owner_q     <= st_owner_d;
      st_op_q        <= st_op_d;
      exp_q          <= exp_d;
      mant_q         <= mant_d;
      tv_q           <= tv_d;
      to_q           <= to_d;
      top_q          <= top_d;
      ret_valid_q    <= ret_valid_d;
      ret_owner_q    <= ret_owner_d;
      r0_res_valid_q <= r0_res_valid_d;
      r1_res_valid_q <= r1_res_valid_d;
      r0_res_q       <= r0_res_d;
      r1_res_q       <= r1_res_d;
    end
  end

  generate
    if (OP_STAGE == 0) begin : g_op_staged
      assign fpa_op = st_valid_q & st_op_q;
    end else begin : g_op_tracked
      assign fpa_op = tv_q[OP_STAGE-1] & top_q[OP_STAGE-1];
    end
  endgenerate

  assign fpa_exponenti = exp_q;
  assign fpa_mantise   = mant_q;
  assign fpa_clear     = fpa_clear_q;
  assign r0_res_valid  = r0_res_valid_q;
  assign r1_res_valid  = r1_res_valid_q;
  assign r0_res        = r0_res_q;
  assign r1_res        = r1_res_q;
  assign busy          = fpa_load | ret_valid_q | r0_res_valid_q | r1_res_valid_q;
  assign inflight      = cnt;

endmodule

// File: tb/tb_fpa_scheduler.sv
// Bench for fpa_scheduler: behavioural pipelined adder, scoreboard of expected results per owner and cycle.
module tb_fpa_scheduler;
  localparam int PD = 4;
  localparam int OS = 2;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic        r0_op = 1'b0, r1_op = 1'b0;
  logic        r0_ready, r1_ready, r0_res_valid, r1_res_valid;
  logic [31:0] r0_res, r1_res;
  logic [15:0] fpa_exponenti;
  logic [47:0] fpa_mantise;
  logic        fpa_load, fpa_clear, fpa_op, busy;
  logic [7:0]  fpa_rez_exp;
  logic [23:0] fpa_rez_mant;
  logic [3:0]  inflight;

  fpa_scheduler #(.PIPE_DEPTH(PD), .OP_STAGE(OS)) dut (
    .clk(clk), .clear(clear),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r0_res_valid(r0_res_valid), .r0_res(r0_res),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .r1_res_valid(r1_res_valid), .r1_res(r1_res),
    .fpa_exponenti(fpa_exponenti), .fpa_mantise(fpa_mantise), .fpa_load(fpa_load),
    .fpa_clear(fpa_clear), .fpa_op(fpa_op), .fpa_rez_exp(fpa_rez_exp),
    .fpa_rez_mant(fpa_rez_mant), .busy(busy), .inflight(inflight)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic log_op [0:4095];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // single-precision helpers (normal numbers, exactly representable operands)
  function automatic real to_real(input logic [31:0] x);
    logic [10:0] e11;
    if (x[30:23] == 8'd0) return 0.0;
    e11 = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e11, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] from_real(input real r);
    logic [63:0] d;
    logic [10:0] se;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'd0;
    se = d[62:52] - 11'd896;
    return {d[63], se[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b, input logic op);
    return op ? from_real(to_real(a) - to_real(b)) : from_real(to_real(a) + to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = '0;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(127, 130));
    v[22:19] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  // behavioural adder: result appears on rez after the advance that moves an entry out of the last stage
  logic [15:0] m_e  [PD];
  logic [47:0] m_m  [PD];
  logic        m_op [PD];
  logic [31:0] m_rez = '0;
  initial for (int i = 0; i < PD; i++) begin m_e[i] = '0; m_m[i] = '0; m_op[i] = 1'b0; end
  always @(posedge clk) begin
    if (fpa_load) begin
      m_rez <= fp_add({m_m[PD-1][47], m_e[PD-1][15:8], m_m[PD-1][46:24]},
                      {m_m[PD-1][23], m_e[PD-1][7:0], m_m[PD-1][22:0]}, m_op[PD-1]);
      m_e[0]  <= fpa_exponenti;
      m_m[0]  <= fpa_mantise;
      m_op[0] <= (OS == 0) ? fpa_op : 1'b0;
      for (int i = 1; i < PD; i++) begin
        m_e[i]  <= m_e[i-1];
        m_m[i]  <= m_m[i-1];
        m_op[i] <= (i == OS) ? fpa_op : m_op[i-1];
      end
    end
  end
  assign fpa_rez_exp  = m_rez[30:23];
  assign fpa_rez_mant = {m_rez[31], m_rez[22:0]};

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [63:0] e;
    if (cyc < 4096) log_op[cyc] = fpa_op;
    check("inflight_bound", 64'(inflight > 4'(PD + 1)), 64'd0);
    check("dual_strobe", 64'(r0_res_valid & r1_res_valid), 64'd0);
    if (r0_res_valid || r1_res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res", {62'd0, r1_res_valid, r0_res_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_owner", 64'(r1_res_valid), 64'(e[63]));
        check("res_cycle", 64'(cyc), 64'(e[62:32]));
        check("res_value", 64'(r1_res_valid ? r1_res : r0_res), 64'(e[31:0]));
      end
    end
  end

  // driver tasks
  task automatic drive_cycle(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic op0,
                             input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic op1,
                             output logic g0, output logic g1, output int acc_cyc);
    @(negedge clk);
    r0_valid = v0; r0_a = a0; r0_b = b0; r0_op = op0;
    r1_valid = v1; r1_a = a1; r1_b = b1; r1_op = op1;
    #1;
    g0 = v0 & r0_ready;
    g1 = v1 & r1_ready;
    acc_cyc = cyc + 1;
    if (g0) exp_q.push_back({1'b0, 31'(acc_cyc + PD + 2), fp_add(a0, b0, op0)});
    if (g1) exp_q.push_back({1'b1, 31'(acc_cyc + PD + 2), fp_add(a1, b1, op1)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      r0_valid = 1'b0;
      r1_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  task automatic do_clear(input int n);
    @(negedge clk);
    clear = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
    exp_q.delete();
    repeat (n) @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    logic g0, g1;
    int e0, tmp;
    logic [3:0] op_seq;
    logic [31:0] a, b, c, d;

    // reset state, with both requesters asking during clear
    r0_valid = 1'b1; r1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_r0_ready", 64'(r0_ready), 64'd0);
    check("rst_r1_ready", 64'(r1_ready), 64'd0);
    check("rst_res_valid", {62'd0, r1_res_valid, r0_res_valid}, 64'd0);
    check("rst_res", {r1_res, r0_res}, 64'd0);
    check("rst_load", 64'(fpa_load), 64'd0);
    check("rst_op", 64'(fpa_op), 64'd0);
    check("rst_exp", 64'(fpa_exponenti), 64'd0);
    check("rst_mant", 64'(fpa_mantise), 64'd0);
    check("rst_fpa_clear", 64'(fpa_clear), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    r0_valid = 1'b0; r1_valid = 1'b0; clear = 1'b0;

    // single op + drain
    drive_cycle(1'b1, 32'h40900000, 32'h40500000, 1'b0, 1'b0, '0, '0, 1'b0, g0, g1, e0);
    check("single_grant", 64'(g0), 64'd1);
    for (int k = 0; k <= PD + 3; k++) begin
      @(negedge clk);
      r0_valid = 1'b0;
      if (k == 0) begin
        check("single_exp", 64'(fpa_exponenti), 64'h8180);
        check("single_mant", 64'(fpa_mantise), 64'h100000500000);
        check("single_inflight", 64'(inflight), 64'd1);
      end
      check($sformatf("drain_load_%0d", k), 64'(fpa_load), 64'(k <= PD));
      check($sformatf("drain_busy_%0d", k), 64'(busy), 64'(k <= PD + 2));
    end
    check("single_res", 64'(r0_res), 64'h40F80000);
    wait_drain();

    // tie for 4 cycles after reset
    do_clear(2);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)),
                  1'b1, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), g0, g1, tmp);
`ifdef FPA_SCHED_FIXED_PRIO_EN
      check($sformatf("tie_g0_%0d", k), 64'(g0), 64'd1);
      check($sformatf("tie_g1_%0d", k), 64'(g1), 64'd0);
`else
      check($sformatf("tie_g0_%0d", k), 64'(g0), 64'((k % 2) == 0));
      check($sformatf("tie_g1_%0d", k), 64'(g1), 64'((k % 2) == 1));
`endif
    end
    wait_drain();

    // op routing: ops 1,0,1,0 back-to-back
    op_seq = 4'b0101;
    e0 = 0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, rand_fp(), rand_fp(), op_seq[k], 1'b0, '0, '0, 1'b0, g0, g1, tmp);
      if (k == 0) e0 = tmp;
      check($sformatf("oprt_grant_%0d", k), 64'(g0), 64'd1);
    end
    wait_drain();
    for (int k = 0; k < OS + 6; k++) begin
      check($sformatf("fpa_op_%0d", k), 64'(log_op[e0 + k]),
            64'((k >= OS && k < OS + 4) ? op_seq[k - OS] : 1'b0));
    end

    // clear mid-flight drops three accepted ops
    a = rand_fp(); b = rand_fp(); c = rand_fp(); d = rand_fp();
    drive_cycle(1'b1, a, b, 1'b0, 1'b0, '0, '0, 1'b0, g0, g1, tmp);
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, c, d, 1'b1, g0, g1, tmp);
    drive_cycle(1'b1, d, a, 1'b1, 1'b0, '0, '0, 1'b0, g0, g1, tmp);
    idle(1);
    @(negedge clk);
    clear = 1'b1;
    exp_q.delete();
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clr_inflight", 64'(inflight), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_fpa_clear", 64'(fpa_clear), 64'd1);
    drive_cycle(1'b1, b, c, 1'b0, 1'b0, '0, '0, 1'b0, g0, g1, tmp);
    check("clr_new_grant", 64'(g0), 64'd1);
    wait_drain();

    // random traffic, both requesters
    for (int k = 0; k < 40; k++) begin
      drive_cycle(1'($urandom_range(0, 1)), rand_fp(), rand_fp(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), g0, g1, tmp);
    end
    wait_drain();
    check("final_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
